palette_lookup_arbiter: RTL and testbench
=========================================

Name: palette_lookup_arbiter

Overview:
- Shares one 16-entry x 12-bit sprite palette lookup between NUM_REQ pixel requesters (player sprites, projectiles, background layer).
- Arbitration is round-robin with a valid/ready handshake.
- The block drives the palette index, registers the returned RGB with a requester ID and a transparency flag, and holds the result under consumer backpressure.
- It sits between the sprite address/ROM stages and the per-pixel compositor feeding VGA colour output.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- TRANSPARENT_KEY, 12'hF0F, RGB value flagged as transparent (magenta, palette entry 0).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_index  in  4*NUM_REQ  per-requester palette index; requester i uses bits [4i+3:4i].
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when req_valid[i] and req_ready[i] are both high.
- pal_index  out  4  index driven to the shared combinational palette lookup.
- pal_rgb  in  12  {red,green,blue} returned combinationally by the palette for pal_index.
- rsp_valid  out  1  result register holds a valid lookup.
- rsp_ready  in  1  consumer accepts the result this cycle.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_red, rsp_green, rsp_blue  out  4 each  registered colour.
- rsp_transparent  out  1  high when registered colour == TRANSPARENT_KEY.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_red/green/blue=0, rsp_transparent=0, last_grant=NUM_REQ-1. Consequence: requester 0 has top priority in the first cycle after reset.
- While Reset=1: req_ready=0 and pal_index=0. No grant occurs during the reset cycle, even if a result is pending or a request is valid.
- Output register states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- accept = Reset=0 and (state==EMPTY or rsp_ready=1).
- Grant selection (combinational, same cycle):
  - Only when accept=1.
  - Scan requesters starting at (last_grant+1) mod NUM_REQ and wrap.
  - g = first i with req_valid[i]=1.
  - req_ready[g]=1; all other bits 0.
  - No valid request or accept=0: req_ready all 0.
  - req_ready never depends on req_valid of the same requester beyond the selection above. A requester may drop valid freely while not granted.
- pal_index = req_index of g when granted, else 0.
- On the rising edge with a grant:
  - rsp_{red,green,blue} <= pal_rgb.
  - rsp_id <= g.
  - rsp_transparent <= (pal_rgb==TRANSPARENT_KEY).
  - rsp_valid <= 1.
  - last_grant <= g.
  - Next state FULL.
- On the rising edge with accept=1, no grant: rsp_valid <= 0 (EMPTY). Data/id/transparent registers retain their last values. last_grant is unchanged.
- FULL and rsp_ready=0: all response outputs hold stable; no grant; last_grant is unchanged.
- Latency and throughput:
  - Exactly 1 cycle from handshake to rsp_valid.
  - Simultaneous consume + new grant in the same cycle gives back-to-back results. Sustained throughput is 1 lookup/cycle when rsp_ready=1.
- Fairness: with all NUM_REQ requesters continuously valid and rsp_ready=1, grants cycle 0,1,2,...,NUM_REQ-1,0. Each requester waits at most NUM_REQ-1 grants.
- Single requester continuously valid: granted every accept cycle.
- Reset asserted mid-operation: the pending result is discarded (rsp_valid=0 next edge), the pointer is restored, and no partial handshake is reported.
- Transparency: a 12-bit equality compare on the palette output, not the index. Any index that maps to F0F is flagged.

Test Plan:
1. Reset, then req_valid=4'b0001, index0=3, rsp_ready=1 -> req_ready=4'b0001 same cycle. Next cycle rsp_valid=1, id=0, rgb=2/6/2, transparent=0.
2. All four requesters valid every cycle, indices 7/11/0/13, rsp_ready=1 -> grants 0,1,2,3,0 in consecutive cycles. Results DB7, E1E, F0F(transparent=1), B85.
3. Requester 1 valid, index 5, rsp_ready held 0 for 3 cycles after the result -> rsp stays B19/id=1 stable. req_ready=0 while a second request (req2, index 9) waits. Result 411 appears the cycle after rsp_ready=1.
4. last_grant=2, requesters 0 and 1 valid -> requester 0 granted first (wrap), then 1.
5. Reset asserted while FULL with req_valid=4'b1111 -> req_ready=0 that cycle. rsp_valid=0 next edge. After release, requester 0 granted first.
6. No requests for 5 cycles after a consumed result -> rsp_valid=0, pal_index=0, req_ready=0, last_grant unchanged.

Source files
------------

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter: round-robin share of one 16x12 palette
// lookup among NUM_REQ pixel requesters, with a registered result.
module palette_lookup_arbiter #(
  parameter int          NUM_REQ         = 4,
  parameter int          ID_W            = 2,
  parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_index,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           pal_index,
  input  logic [11:0]          pal_rgb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_red,
  output logic [3:0]           rsp_green,
  output logic [3:0]           rsp_blue,
  output logic                 rsp_transparent
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t               state;
  logic [ID_W-1:0]      last_grant;
  logic                 accept;
  logic                 found;
  logic                 grant;
  logic [NUM_REQ-1:0]   onehot;
  logic [ID_W-1:0]      gid;
  logic [3:0]           gidx;

  // The result slot can take a new lookup when empty or being drained.
  always_comb begin
    accept = !Reset && ((state == EMPTY) || rsp_ready);
  end

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    gid    = '0;
    gidx   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        gid       = ID_W'(j);
        gidx      = req_index[4*j +: 4];
        onehot[j] = 1'b1;
      end
    end
  end

  // Grant and palette address are only driven when a lookup is taken.
  always_comb begin
    grant     = accept && found;
    req_ready = grant ? onehot : '0;
    pal_index = grant ? gidx : 4'd0;
  end

  // Result register: load on grant, empty on drain, hold otherwise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= EMPTY;
      rsp_id          <= '0;
      rsp_red         <= 4'd0;
      rsp_green       <= 4'd0;
      rsp_blue        <= 4'd0;
      rsp_transparent <= 1'b0;
      last_grant      <= ID_W'(NUM_REQ - 1);
    end else if (grant) begin
      state           <= FULL;
      rsp_id          <= gid;
      rsp_red         <= pal_rgb[11:8];
      rsp_green       <= pal_rgb[7:4];
      rsp_blue        <= pal_rgb[3:0];
      rsp_transparent <= (pal_rgb == TRANSPARENT_KEY);
      last_grant      <= gid;
    end else if (accept) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// tb_palette_lookup_arbiter: directed scenarios plus random traffic
// compared against a cycle-level model of the arbiter.
module tb_palette_lookup_arbiter;

  localparam int N = 4;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_index;
  logic [N-1:0]   req_ready;
  logic [3:0]     pal_index;
  logic [11:0]    pal_rgb;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [3:0]     rsp_red;
  logic [3:0]     rsp_green;
  logic [3:0]     rsp_blue;
  logic           rsp_transparent;

  logic [11:0] pal [16];

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          ptr;
  bit          mv;
  int          mid;
  logic [11:0] mrgb;

  always #5 Clk = ~Clk;

  assign pal_rgb = pal[pal_index];

  palette_lookup_arbiter #(
    .NUM_REQ(N),
    .ID_W(2),
    .TRANSPARENT_KEY(12'hF0F)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .req_valid(req_valid),
    .req_index(req_index),
    .req_ready(req_ready),
    .pal_index(pal_index),
    .pal_rgb(pal_rgb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_red(rsp_red),
    .rsp_green(rsp_green),
    .rsp_blue(rsp_blue),
    .rsp_transparent(rsp_transparent)
  );

  function automatic logic [3:0] idx_of(int i);
    logic [4*N-1:0] v;
    v = req_index;
    return v[4*i +: 4];
  endfunction

  function automatic int model_grant();
    int g;
    int j;
    g = -1;
    if (Reset) return -1;
    if (mv && !rsp_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      j = (ptr + k) % N;
      if (req_valid[j]) begin
        g = j;
        break;
      end
    end
    return g;
  endfunction

  function automatic logic [N-1:0] onehot_of(int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [4*N-1:0] idx,
                       input logic rr, input logic rst);
    req_valid = v;
    req_index = idx;
    rsp_ready = rr;
    Reset     = rst;
    #1;
  endtask

  task automatic tick();
    int g;
    g = model_grant();
    @(posedge Clk);
    if (Reset) begin
      mv = 0; mid = 0; mrgb = 12'h000; ptr = N - 1;
    end else if (g >= 0) begin
      mv = 1; mid = g; mrgb = pal[idx_of(g)]; ptr = g;
    end else if (rsp_ready) begin
      mv = 0;
    end
    @(negedge Clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'b1111, 16'h1234, 1'b1, 1'b1);
    tick();
    checks++;
    if (req_ready !== 4'b0000 || pal_index !== 4'd0) begin
      failures++;
      $display("FAIL reset_grant: ready=%b idx=%0d want 0000/0", req_ready, pal_index);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_transparent !== 1'b0 ||
        {rsp_red, rsp_green, rsp_blue} !== 12'h000) begin
      failures++;
      $display("FAIL reset_regs: v=%b id=%0d rgb=%h t=%b want 0/0/000/0",
               rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent);
    end
  endtask

  task automatic test_single();
    drive(4'b0001, 16'h0003, 1'b1, 1'b0);
    checks++;
    if (req_ready !== 4'b0001 || pal_index !== 4'd3) begin
      failures++;
      $display("FAIL single_grant: ready=%b idx=%0d want 0001/3", req_ready, pal_index);
    end
    tick();
    drive(4'b0000, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
        {rsp_red, rsp_green, rsp_blue} !== 12'h262 || rsp_transparent !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: v=%b id=%0d rgb=%h t=%b want 1/0/262/0",
               rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_rgb [4];
    exp_rgb[0] = 12'hDB7;
    exp_rgb[1] = 12'hE1E;
    exp_rgb[2] = 12'hF0F;
    exp_rgb[3] = 12'hB85;
    drive(4'b0000, 16'h0000, 1'b1, 1'b1);
    tick();
    drive(4'b1111, {4'd13, 4'd0, 4'd11, 4'd7}, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (req_ready !== onehot_of(c % 4)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: ready=%b want %b", c, req_ready, onehot_of(c % 4));
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % 4) ||
          {rsp_red, rsp_green, rsp_blue} !== exp_rgb[c % 4] ||
          rsp_transparent !== ((c % 4) == 2)) begin
        failures++;
        $display("FAIL rr_rsp[%0d]: v=%b id=%0d rgb=%h t=%b want 1/%0d/%h/%b", c,
                 rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent,
                 c % 4, exp_rgb[c % 4], (c % 4) == 2);
      end
    end
  endtask

  task automatic test_backpressure();
    drive(4'b0000, 16'h0000, 1'b1, 1'b1);
    tick();
    drive(4'b0010, 16'h0050, 1'b1, 1'b0);
    tick();
    drive(4'b0100, 16'h0900, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 ||
          {rsp_red, rsp_green, rsp_blue} !== 12'hB19) begin
        failures++;
        $display("FAIL bp_hold[%0d]: ready=%b v=%b id=%0d rgb=%h want 0000/1/1/B19",
                 c, req_ready, rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue});
      end
      tick();
    end
    drive(4'b0100, 16'h0900, 1'b1, 1'b0);
    checks++;
    if (req_ready !== 4'b0100 || pal_index !== 4'd9) begin
      failures++;
      $display("FAIL bp_release: ready=%b idx=%0d want 0100/9", req_ready, pal_index);
    end
    tick();
    drive(4'b0000, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
        {rsp_red, rsp_green, rsp_blue} !== 12'h411) begin
      failures++;
      $display("FAIL bp_next: v=%b id=%0d rgb=%h want 1/2/411",
               rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue});
    end
    tick();
  endtask

  task automatic test_wrap();
    drive(4'b0011, 16'h0021, 1'b1, 1'b0);
    checks++;
    if (req_ready !== 4'b0001 || pal_index !== 4'd1) begin
      failures++;
      $display("FAIL wrap_first: ready=%b idx=%0d want 0001/1", req_ready, pal_index);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0010 || pal_index !== 4'd2 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL wrap_second: ready=%b idx=%0d id=%0d want 0010/2/0",
               req_ready, pal_index, rsp_id);
    end
    tick();
    checks++;
    if (rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_rsp: id=%0d v=%b want 1/1", rsp_id, rsp_valid);
    end
  endtask

  task automatic test_reset_full();
    drive(4'b1111, {4'd13, 4'd0, 4'd11, 4'd7}, 1'b1, 1'b1);
    checks++;
    if (req_ready !== 4'b0000 || pal_index !== 4'd0) begin
      failures++;
      $display("FAIL rstfull_grant: ready=%b idx=%0d want 0000/0", req_ready, pal_index);
    end
    tick();
    drive(4'b1111, {4'd13, 4'd0, 4'd11, 4'd7}, 1'b1, 1'b0);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rstfull_after: v=%b ready=%b want 0/0001", rsp_valid, req_ready);
    end
    tick();
    checks++;
    if (rsp_id !== 2'd0 || {rsp_red, rsp_green, rsp_blue} !== 12'hDB7) begin
      failures++;
      $display("FAIL rstfull_rsp: id=%0d rgb=%h want 0/DB7",
               rsp_id, {rsp_red, rsp_green, rsp_blue});
    end
  endtask

  task automatic test_idle();
    drive(4'b0000, 16'hFFFF, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b0 || pal_index !== 4'd0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL idle[%0d]: v=%b idx=%0d ready=%b want 0/0/0000",
                 c, rsp_valid, pal_index, req_ready);
      end
      tick();
    end
    checks++;
    if (rsp_id !== 2'd0 || {rsp_red, rsp_green, rsp_blue} !== 12'hDB7) begin
      failures++;
      $display("FAIL idle_retain: id=%0d rgb=%h want 0/DB7",
               rsp_id, {rsp_red, rsp_green, rsp_blue});
    end
    drive(4'b1111, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL idle_ptr: ready=%b want 0010", req_ready);
    end
  endtask

  task automatic test_alias_key();
    drive(4'b1000, 16'hC000, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (rsp_transparent !== 1'b1 || rsp_id !== 2'd3) begin
      failures++;
      $display("FAIL alias_key: t=%b id=%0d want 1/3", rsp_transparent, rsp_id);
    end
    tick();
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 600; c++) begin
      drive(4'($urandom), 16'($urandom), ($urandom_range(3) != 0),
            ($urandom_range(49) == 0));
      g = model_grant();
      checks++;
      if (req_ready !== onehot_of(g) ||
          pal_index !== ((g >= 0) ? idx_of(g) : 4'd0)) begin
        failures++;
        $display("FAIL rnd_grant[%0d]: ready=%b idx=%0d want %b/%0d", c,
                 req_ready, pal_index, onehot_of(g), (g >= 0) ? idx_of(g) : 4'd0);
      end
      checks++;
      if (rsp_valid !== mv || rsp_id !== 2'(mid) ||
          {rsp_red, rsp_green, rsp_blue} !== mrgb ||
          rsp_transparent !== (mrgb == 12'hF0F)) begin
        failures++;
        $display("FAIL rnd_rsp[%0d]: v=%b id=%0d rgb=%h t=%b want %b/%0d/%h/%b", c,
                 rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent,
                 mv, mid, mrgb, mrgb == 12'hF0F);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
    pal[0]  = 12'hF0F;
    pal[3]  = 12'h262;
    pal[5]  = 12'hB19;
    pal[7]  = 12'hDB7;
    pal[9]  = 12'h411;
    pal[11] = 12'hE1E;
    pal[12] = 12'hF0F;
    pal[13] = 12'hB85;
    mv = 0; mid = 0; mrgb = 12'h000; ptr = N - 1;
    Reset = 1'b1;
    req_valid = '0;
    req_index = '0;
    rsp_ready = 1'b0;
    @(negedge Clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_full();
    test_idle();
    test_alias_key();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
